// File: rtl/detect_stream_ctrl_pkg.sv
// Shared encodings and the six-state detector transition function
// used by the stream sequencer and its detector core.
package detect_stream_ctrl_pkg;

    localparam logic [2:0] DET_A = 3'd0;
    localparam logic [2:0] DET_B = 3'd1;
    localparam logic [2:0] DET_C = 3'd2;
    localparam logic [2:0] DET_D = 3'd3;
    localparam logic [2:0] DET_E = 3'd4;
    localparam logic [2:0] DET_F = 3'd5;

    localparam logic [1:0] CTRL_IDLE   = 2'd0;
    localparam logic [1:0] CTRL_SHIFT  = 2'd1;
    localparam logic [1:0] CTRL_REPORT = 2'd2;

    // Unused encodings 6 and 7 fall back to A.
    function automatic logic [2:0] det_next(input logic [2:0] s, input logic w);
        logic [2:0] n;
        case (s)
            DET_A:   n = w ? DET_C : DET_B;
            DET_B:   n = w ? DET_E : DET_D;
            DET_C:   n = w ? DET_D : DET_E;
            DET_D:   n = w ? DET_F : DET_A;
            DET_E:   n = w ? DET_A : DET_F;
            DET_F:   n = w ? DET_C : DET_B;
            default: n = DET_A;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/detect_stream_ctrl_core.sv
// Six-state serial pattern detector; advances only on step, clear wins over step.
module detect_core
    import detect_stream_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic       clear,
    input  logic       w,
    output logic [2:0] state,
    output logic       next_is_f
);

    logic [2:0] nxt;

    assign nxt       = det_next(state, w);
    assign next_is_f = (nxt == DET_F);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= DET_A;
        else if (clear)
            state <= DET_A;
        else if (step)
            state <= nxt;
    end

endmodule

// File: rtl/detect_stream_ctrl.sv
// Serialises valid/ready words MSB first into the detector and reports
// the per-word hit count and the detector state after the last bit.
module detect_stream_ctrl
    import detect_stream_ctrl_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_hits,
    output logic [2:0]        out_final_state,
    output logic              busy
);

    localparam int IDX_W = $clog2(WORD_W) + 1;

    logic [1:0]        ctrl;
    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  hits;
    logic [CNT_W-1:0]  hits_nxt;
    logic [IDX_W-1:0]  idx;
    logic [2:0]        det_state;
    logic              next_is_f;
    logic              accept;
    logic              last_bit;

    assign in_ready  = (ctrl == CTRL_IDLE);
    assign out_valid = (ctrl == CTRL_REPORT);
    assign busy      = (ctrl != CTRL_IDLE);
    assign accept    = in_ready && in_valid;
    assign last_bit  = (idx == IDX_W'(WORD_W - 1));

    // Saturating so an undersized CNT_W pins at all-ones instead of wrapping.
    assign hits_nxt  = (next_is_f && (hits != {CNT_W{1'b1}})) ? hits + CNT_W'(1) : hits;

    detect_core u_core (
        .clk       (clk),
        .reset     (reset),
        .step      (ctrl == CTRL_SHIFT),
        .clear     (accept && in_clear),
        .w         (shreg[WORD_W-1]),
        .state     (det_state),
        .next_is_f (next_is_f)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl            <= CTRL_IDLE;
            shreg           <= '0;
            hits            <= '0;
            idx             <= '0;
            out_hits        <= '0;
            out_final_state <= DET_A;
        end else begin
            case (ctrl)
                CTRL_IDLE: begin
                    if (in_valid) begin
                        shreg <= in_data;
                        hits  <= '0;
                        idx   <= '0;
                        ctrl  <= CTRL_SHIFT;
                    end
                end
                CTRL_SHIFT: begin
                    shreg <= shreg << 1;
                    idx   <= idx + IDX_W'(1);
                    hits  <= hits_nxt;
                    // Result is captured on the last step so it stays put through REPORT.
                    if (last_bit) begin
                        out_hits        <= hits_nxt;
                        out_final_state <= det_next(det_state, shreg[WORD_W-1]);
                        ctrl            <= CTRL_REPORT;
                    end
                end
                CTRL_REPORT: begin
                    if (out_ready)
                        ctrl <= CTRL_IDLE;
                end
                default: ctrl <= CTRL_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_detect_stream_ctrl.sv
// Bench for detect_stream_ctrl: directed scenarios plus random words,
// checked against a word-level detector model and literal expectations.
module tb_detect_stream_ctrl;

    localparam int WORD_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WORD_W-1:0] in_data = '0;
    logic              in_clear = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CNT_W-1:0]  out_hits;
    logic [2:0]        out_final_state;
    logic              busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Transition table from the detector description: next[state][bit].
    int tbl [6][2] = '{'{1, 2}, '{3, 4}, '{4, 3}, '{0, 5}, '{5, 0}, '{1, 2}};
    int mstate = 0;
    int exp_q [$];   // packed as hits*8 + final_state

    detect_stream_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_clear        (in_clear),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_hits        (out_hits),
        .out_final_state (out_final_state),
        .busy            (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Whole-word result: walk the bits MSB first and count arrivals in F.
    function automatic int model_word(input logic [WORD_W-1:0] d, input logic clr,
                                      inout int st);
        int h = 0;
        if (clr) st = 0;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            st = tbl[st][d[i]];
            if (st == 5) h++;
        end
        if (h > (1 << CNT_W) - 1) h = (1 << CNT_W) - 1;
        return h * 8 + st;
    endfunction

    // Compare process: every result cycle checked against the model queue.
    always @(negedge clk) begin
        if (reset) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    chk("out_hits", int'(out_hits), exp_q[0] / 8);
                    chk("out_final_state", int'(out_final_state), exp_q[0] % 8);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                int st;
                st = mstate;
                exp_q.push_back(model_word(in_data, in_clear, st));
                mstate = st;
            end
        end
    end

    task automatic wait_result(output int k);
        k = 0;
        while (!out_valid && k < 4 * WORD_W) begin
            @(posedge clk); #1; k++;
        end
        if (!out_valid) chk("result_timeout", 0, 1);
    endtask

    // Called #1 after a rising edge. exp_hits < 0 skips literal checks.
    task automatic send(input logic [WORD_W-1:0] d, input logic clr, input int hold,
                        input int exp_hits, input int exp_fin, input bit chk_lat);
        int k;
        in_data = d; in_clear = clr; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1; k++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_clear = 1'b0;
        wait_result(k);
        if (chk_lat) chk("latency", k, WORD_W);
        if (exp_hits >= 0) begin
            chk("lit_hits", int'(out_hits), exp_hits);
            chk("lit_final", int'(out_final_state), exp_fin);
        end
        for (int h = 0; h < hold; h++) begin
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_busy", int'(busy), 1);
            in_valid = 1'b1; in_data = ~d;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_in_ready", int'(in_ready), 1);
        chk("idle_out_valid", int'(out_valid), 0);
        chk("idle_busy", int'(busy), 0);
    endtask

    initial begin
        int k, a1, a2;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_hits", int'(out_hits), 0);
        chk("rst_final", int'(out_final_state), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        send(8'h00, 1'b1, 0, 0, 3, 1'b1);
        send(8'b0010_0100, 1'b1, 0, 2, 3, 1'b1);
        send(8'hFF, 1'b1, 0, 2, 3, 1'b0);
        send(8'hFF, 1'b0, 0, 3, 2, 1'b0);
        send(8'b0101_0101, 1'b1, 5, 1, 4, 1'b0);

        // Reset in the middle of a word: result dropped, everything back to reset values.
        in_data = 8'hFF; in_clear = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete(); mstate = 0;
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_hits", int'(out_hits), 0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        send(8'b0010_0100, 1'b0, 0, 2, 3, 1'b0);

        // Back-to-back words with the consumer always ready, starting from A.
        reset = 1'b0; exp_q.delete(); mstate = 0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_data = 8'h00; in_clear = 1'b0; in_valid = 1'b1;
        @(posedge clk); a1 = cyc; #1;
        in_data = 8'hFF;
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1; k++;
        end
        @(posedge clk); a2 = cyc; #1;
        in_valid = 1'b0;
        chk("b2b_spacing", a2 - a1, WORD_W + 2);
        wait_result(k);
        chk("b2b_hits", int'(out_hits), 3);
        chk("b2b_final", int'(out_final_state), 2);
        @(posedge clk); #1;
        out_ready = 1'b0;

        for (int i = 0; i < 40; i++)
            send(WORD_W'($urandom), 1'($urandom % 2), int'($urandom % 3), -1, 0, 1'b0);

        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
